// File: rtl/main_memory_responder.sv
// Main-memory responder: self-initialising store serving 4-word line fills, critical word first.
// Define MEM_WRITE_EN to build the line write-back path (WRITE state and store write port from wr_data).
module main_memory_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              init_done
);

  localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int IDX_W  = DEPTH_LOG2;
  localparam int BASE_W = DEPTH_LOG2 - 2;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT,
    S_READ
`ifdef MEM_WRITE_EN
    , S_WRITE
`endif
  } state_t;

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  state_t            r_state, w_next, w_acc_dst, w_wait_dst;
  logic [IDX_W-1:0]  r_init_cnt;
  logic              r_init_done;
  logic [BASE_W-1:0] r_base;
  logic [1:0]        r_beat, r_cnt;
  logic [LAT_W-1:0]  r_lat;
  logic              r_rd_valid, r_rd_last;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_accept, w_rd_hs, w_wr_hs, w_beat_hs, w_last_hs, w_rd_load;
  logic [IDX_W-1:0]  w_req_idx, w_cur_idx, w_nxt_idx, w_raddr, w_waddr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused;

  assign w_req_idx = req_addr[DEPTH_LOG2+2:3];
  assign w_cur_idx = {r_base, r_beat};
  assign w_nxt_idx = {r_base, r_beat + 2'd1};

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_rd_hs   = (r_state == S_READ) && rd_ready;
  assign w_beat_hs = w_rd_hs || w_wr_hs;
  assign w_last_hs = w_beat_hs && (r_cnt == 2'd3);

`ifdef MEM_WRITE_EN
  logic r_write;
  assign w_wr_hs    = (r_state == S_WRITE) && wr_valid;
  assign w_acc_dst  = req_write ? S_WRITE : S_READ;
  assign w_wait_dst = r_write ? S_WRITE : S_READ;
  assign wr_ready   = (r_state == S_WRITE);
  assign w_wdata    = (r_state == S_INIT) ? DATA_W'(r_init_cnt) : wr_data;
  assign w_unused   = ^req_addr;
`else
  assign w_wr_hs    = 1'b0;
  assign w_acc_dst  = S_READ;
  assign w_wait_dst = S_READ;
  assign wr_ready   = 1'b0;
  assign w_wdata    = DATA_W'(r_init_cnt);
  assign w_unused   = ^{req_addr, req_write, wr_valid, wr_data};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == '1) w_next = S_IDLE;
      S_IDLE:  if (req_valid) w_next = (LATENCY > 0) ? S_WAIT : w_acc_dst;
      S_WAIT:  if (r_lat == LAT_W'(1)) w_next = w_wait_dst;
      S_READ:  if (w_last_hs) w_next = S_IDLE;
`ifdef MEM_WRITE_EN
      S_WRITE: if (w_last_hs) w_next = S_IDLE;
`endif
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  // First beat is fetched on READ entry; later beats on each handshake, so data holds while stalled.
  assign w_rd_load = (r_state != S_READ) && (w_next == S_READ);
  assign w_raddr   = (r_state == S_IDLE) ? w_req_idx : (w_rd_load ? w_cur_idx : w_nxt_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_base      <= '0;
      r_beat      <= '0;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= '0;
`ifdef MEM_WRITE_EN
      r_write     <= 1'b0;
`endif
    end else begin
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
        if (r_init_cnt == '1) r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_base <= w_req_idx[IDX_W-1:2];
        r_beat <= w_req_idx[1:0];
        r_cnt  <= '0;
        r_lat  <= LAT_W'(LATENCY);
`ifdef MEM_WRITE_EN
        r_write <= req_write;
`endif
      end
      if (r_state == S_WAIT) r_lat <= r_lat - 1'b1;
      if (w_beat_hs) begin
        r_beat <= r_beat + 2'd1;
        r_cnt  <= r_cnt + 2'd1;
      end
      if (w_rd_load) begin
        r_rd_valid <= 1'b1;
        r_rd_last  <= 1'b0;
        r_rd_data  <= r_mem[w_raddr];
      end else if (w_rd_hs) begin
        if (r_cnt == 2'd3) begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
        end else begin
          r_rd_data <= r_mem[w_raddr];
          r_rd_last <= (r_cnt == 2'd2);
        end
      end
    end
  end

  assign w_mem_we = !reset && ((r_state == S_INIT) || w_wr_hs);
  assign w_waddr  = (r_state == S_INIT) ? r_init_cnt : w_cur_idx;

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_waddr] <= w_wdata;
  end

  assign req_ready = (r_state == S_IDLE);
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomised self-checking bench for main_memory_responder against a word-array model of the store.
module tb_main_memory_responder;

  localparam int DEPTH_LOG2 = 12;
  localparam int LATENCY    = 4;
  localparam int WORDS      = 1 << DEPTH_LOG2;

  logic        clock = 1'b0;
  logic        reset, req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic        wr_valid, wr_ready, init_done;
  logic [63:0] wr_data;

  logic [63:0] mdl [WORDS];
  logic [63:0] wdat [4];
  int total = 0;
  int bad   = 0;
  int n, acc;
  logic [31:0] a;
  bit rflag;

  always #5 clock = ~clock;

  main_memory_responder #(
    .ADDR_W(32), .DATA_W(64), .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LATENCY)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .init_done(init_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Word touched by beat k of a line request at byte address addr.
  function automatic int beat_word(input logic [31:0] addr, input int k);
    int unsigned w;
    w = (addr >> 3) % WORDS;
    return int'((w / 4) * 4 + ((w % 4) + k) % 4);
  endfunction

  task automatic model_init();
    for (int i = 0; i < WORDS; i++) mdl[i] = 64'(i);
  endtask

  task automatic wait_init();
    int cyc;
    bit early;
    reset = 1'b0;
    cyc = 0;
    early = 1'b0;
    while (!init_done && cyc < 5000) begin
      @(negedge clock);
      cyc++;
      if (!init_done && req_ready) early = 1'b1;
    end
    check("init_cycles", 64'(cyc), 64'(WORDS));
    check("req_ready_at_init_done", 64'(req_ready), 64'd1);
    check("req_ready_during_init", 64'(early), 64'd0);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int mode, input bit wr_flag,
                            input bit keep_valid, input logic [31:0] next_addr, output int acc_wait);
    logic [63:0] want [4];
    int cyc, k, stalls, guard;
    bit rdy;
    for (int i = 0; i < 4; i++) want[i] = mdl[beat_word(addr, i)];
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr_flag;
    acc_wait  = 0;
    while (!req_ready && acc_wait < 100) begin
      @(negedge clock);
      acc_wait++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      req_write = 1'b0;
      return;
    end
    @(negedge clock);
    req_write = 1'b0;
    if (keep_valid) req_addr = next_addr;
    else req_valid = 1'b0;
    cyc = 1;
    while (!rd_valid && cyc < 50) begin
      rd_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      cyc++;
    end
    check("rd_first_beat_cycle", 64'(cyc), 64'(LATENCY + 1));
    check("wr_ready_during_read", 64'(wr_ready), 64'd0);
    k = 0;
    stalls = 0;
    guard = 0;
    while (k < 4 && guard < 100) begin
      guard++;
      if (!rd_valid) begin
        check("rd_valid_in_burst", 64'(rd_valid), 64'd1);
        break;
      end
      check($sformatf("rd_data_beat%0d", k), rd_data, want[k]);
      check($sformatf("rd_last_beat%0d", k), 64'(rd_last), 64'(k == 3));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(k == 1 && stalls < 3);
          if (!rdy) stalls++;
        end
      endcase
      rd_ready = rdy;
      @(negedge clock);
      if (rdy) k++;
    end
    rd_ready = 1'b0;
    check("rd_beat_count", 64'(k), 64'd4);
    check("rd_valid_after_last", 64'(rd_valid), 64'd0);
    check("req_ready_after_last", 64'(req_ready), 64'd1);
  endtask

`ifdef MEM_WRITE_EN
  task automatic write_burst(input logic [31:0] addr);
    int cyc, k, guard;
    bit v;
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    req_write = 1'b0;
    cyc = 1;
    while (!wr_ready && cyc < 50) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = {$urandom, $urandom};
      @(negedge clock);
      cyc++;
    end
    check("wr_first_cycle", 64'(cyc), 64'(LATENCY + 1));
    k = 0;
    guard = 0;
    while (k < 4 && guard < 100) begin
      guard++;
      if (!wr_ready) begin
        check("wr_ready_in_burst", 64'(wr_ready), 64'd1);
        break;
      end
      v = ($urandom_range(0, 3) != 0);
      wr_valid = v;
      wr_data  = v ? wdat[k] : {$urandom, $urandom};
      @(negedge clock);
      if (v) begin
        mdl[beat_word(addr, k)] = wdat[k];
        k++;
      end
    end
    wr_valid = 1'b0;
    check("wr_beat_count", 64'(k), 64'd4);
    check("wr_ready_after_last", 64'(wr_ready), 64'd0);
    check("req_ready_after_write", 64'(req_ready), 64'd1);
  endtask
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0;
    model_init();
    @(negedge clock);
    @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", rd_data, 64'd0);
    check("rst_rd_last", 64'(rd_last), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    wait_init();

    // Critical word first, then the same line with a 3-cycle stall on beat 2.
    read_burst(32'd65688, 0, 1'b0, 1'b0, 32'd0, acc);
    read_burst(32'd65688, 2, 1'b0, 1'b0, 32'd0, acc);

`ifdef MEM_WRITE_EN
    wdat[0] = 64'hA0; wdat[1] = 64'hA1; wdat[2] = 64'hA2; wdat[3] = 64'hA3;
    write_burst(32'h20);
    read_burst(32'h20, 0, 1'b0, 1'b0, 32'd0, acc);
`else
    read_burst(32'h20, 0, 1'b1, 1'b0, 32'd0, acc);
`endif

    // Back-to-back with req_valid held high.
    read_burst(32'h0, 0, 1'b0, 1'b1, 32'h40, acc);
    read_burst(32'h40, 0, 1'b0, 1'b0, 32'd0, acc);
    check("b2b_accept_wait", 64'(acc), 64'd0);

    for (int it = 0; it < 16; it++) begin
      a = $urandom;
`ifdef MEM_WRITE_EN
      rflag = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j < 4; j++) wdat[j] = {$urandom, $urandom};
        write_burst(a);
        a = a ^ ($urandom & 32'h18);
      end
`else
      rflag = 1'($urandom_range(0, 1));
`endif
      read_burst(a, 1, rflag, 1'b0, 32'd0, acc);
    end

    // Reset during beat 2 of a read.
    req_valid = 1'b1; req_addr = 32'h20; req_write = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!rd_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    rd_ready = 1'b1;
    @(negedge clock);
    rd_ready = 1'b0;
    check("mid_beat2_valid", 64'(rd_valid), 64'd1);
    check("mid_beat2_data", rd_data, mdl[beat_word(32'h20, 1)]);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("mid_rst_init_done", 64'(init_done), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    check("mid_rst_rd_data", rd_data, 64'd0);
    check("mid_rst_rd_last", 64'(rd_last), 64'd0);
    check("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
    wait_init();
    model_init();
    read_burst(32'h20, 0, 1'b0, 1'b0, 32'd0, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
